// File: rtl/stacker_pkg.sv
// Shared state encodings, direction constants and width helpers for the stacking-game controller.
package stacker_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'b000,
        ST_MOVE  = 3'b001,
        ST_PLACE = 3'b010,
        ST_ALIGN = 3'b100,
        ST_WIN   = 3'b101,
        ST_LOSE  = 3'b111
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int score_w(input int cols, input int rows);
        return $clog2(cols * rows + 1);
    endfunction

    function automatic int count_w(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/stacker_popcount.sv
// Combinational population count of a W-bit row word.
module stacker_popcount
    import stacker_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = count_w(W)
) (
    input  logic [W-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/stacker_engine.sv
// Stacking-game controller: moves a block across the current row, settles it on the row
// below, and drives the row-memory write port, score, level and win/lose flags.
//
// state | meaning
// INIT  | clear array, load initial block, write row 0
// MOVE  | block bounces on step_tick; btn drops it
// PLACE | write overlap with row below; lose, win or continue
// ALIGN | shift survivor to the left edge, then climb a level
// WIN   | top row reached; btn restarts
// LOSE  | nothing overlapped; btn restarts
module stacker_engine
    import stacker_pkg::*;
#(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int INIT_LEN = 3,
    parameter int RW       = row_w(ROWS),
    parameter int SW       = score_w(COLS, ROWS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn,
    input  logic            step_tick,
    output logic            clr_array,
    output logic            wr_en,
    output logic [RW-1:0]   wr_row,
    output logic [COLS-1:0] wr_data,
    output logic [RW-1:0]   level,
    output logic [SW-1:0]   score,
    output logic            win,
    output logic            lose,
    output logic [2:0]      state
);

    localparam int PW = count_w(COLS);
    localparam logic [COLS-1:0] ALL_ONES  = '1;
    localparam logic [COLS-1:0] INIT_CUR  = ~(ALL_ONES >> INIT_LEN);
    localparam logic [SW:0]     SCORE_MAX = (SW + 1)'(COLS * ROWS);
    localparam logic [RW-1:0]   LAST_ROW  = RW'(ROWS - 1);

    state_t          cur_state, next_state;
    logic [COLS-1:0] cur, cur_next;
    logic [COLS-1:0] prev, prev_next;
    logic [COLS-1:0] placed, placed_next;
    logic [COLS-1:0] shifted;
    logic            dir, dir_next;
    logic            bounce;
    logic [RW-1:0]   level_next;
    logic [SW-1:0]   score_next;
    logic            wr_en_next;
    logic [RW-1:0]   wr_row_next;
    logic [COLS-1:0] wr_data_next;
    logic [PW-1:0]   placed_count;
    logic [SW:0]     score_sum;
    logic [SW-1:0]   score_sat;

    stacker_popcount #(.W(COLS), .CW(PW)) u_popcount (
        .bits  (placed),
        .count (placed_count)
    );

    assign clr_array = (cur_state == ST_INIT);
    assign win       = (cur_state == ST_WIN);
    assign lose      = (cur_state == ST_LOSE);
    assign state     = cur_state;

    always_comb begin
        score_sum = {1'b0, score} + (SW + 1)'(placed_count);
        score_sat = (score_sum > SCORE_MAX) ? SCORE_MAX[SW-1:0] : score_sum[SW-1:0];
    end

    // A block touching the edge it is heading for reverses and moves away on the same tick.
    always_comb begin
        bounce = (dir == DIR_RIGHT) ? cur[0] : cur[COLS-1];
        if (&cur) begin
            shifted = cur;
        end else if ((dir == DIR_RIGHT) ^ bounce) begin
            shifted = cur >> 1;
        end else begin
            shifted = cur << 1;
        end
    end

    always_comb begin
        next_state   = cur_state;
        cur_next     = cur;
        prev_next    = prev;
        placed_next  = placed;
        dir_next     = dir;
        level_next   = level;
        score_next   = score;
        wr_en_next   = 1'b0;
        wr_row_next  = wr_row;
        wr_data_next = wr_data;
        case (cur_state)
            ST_INIT: begin
                cur_next     = INIT_CUR;
                prev_next    = ALL_ONES;
                dir_next     = DIR_RIGHT;
                level_next   = '0;
                score_next   = '0;
                wr_en_next   = 1'b1;
                wr_row_next  = '0;
                wr_data_next = INIT_CUR;
                next_state   = ST_MOVE;
            end
            ST_MOVE: begin
                if (btn) begin
                    placed_next = cur & prev;
                    next_state  = ST_PLACE;
                end else if (step_tick) begin
                    cur_next     = shifted;
                    if (!(&cur) && bounce) begin
                        dir_next = ~dir;
                    end
                    wr_en_next   = 1'b1;
                    wr_row_next  = level;
                    wr_data_next = shifted;
                end
            end
            ST_PLACE: begin
                wr_en_next   = 1'b1;
                wr_row_next  = level;
                wr_data_next = placed;
                if (placed == '0) begin
                    next_state = ST_LOSE;
                end else begin
                    score_next = score_sat;
                    if (level == LAST_ROW) begin
                        next_state = ST_WIN;
                    end else begin
                        prev_next  = placed;
                        cur_next   = placed;
                        next_state = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                if (!cur[COLS-1]) begin
                    cur_next = cur << 1;
                end else begin
                    level_next   = level + RW'(1);
                    wr_en_next   = 1'b1;
                    wr_row_next  = level + RW'(1);
                    wr_data_next = cur;
                    dir_next     = DIR_RIGHT;
                    next_state   = ST_MOVE;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (btn) begin
                    score_next = '0;
                    level_next = '0;
                    next_state = ST_INIT;
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_INIT;
            cur       <= '0;
            prev      <= '1;
            placed    <= '0;
            dir       <= DIR_RIGHT;
            level     <= '0;
            score     <= '0;
            wr_en     <= 1'b0;
            wr_row    <= '0;
            wr_data   <= '0;
        end else begin
            cur_state <= next_state;
            cur       <= cur_next;
            prev      <= prev_next;
            placed    <= placed_next;
            dir       <= dir_next;
            level     <= level_next;
            score     <= score_next;
            wr_en     <= wr_en_next;
            wr_row    <= wr_row_next;
            wr_data   <= wr_data_next;
        end
    end

endmodule

// File: tb/tb_stacker_engine.sv
// Self-checking bench for stacker_engine (8x8, block length 3): status table plus write scoreboard.
module tb_stacker_engine;

    localparam logic [2:0] S_INIT  = 3'b000;
    localparam logic [2:0] S_MOVE  = 3'b001;
    localparam logic [2:0] S_PLACE = 3'b010;
    localparam logic [2:0] S_ALIGN = 3'b100;
    localparam logic [2:0] S_WIN   = 3'b101;
    localparam logic [2:0] S_LOSE  = 3'b111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic       step_tick = 1'b0;
    logic       clr_array;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic [2:0] level;
    logic [6:0] score;
    logic       win;
    logic       lose;
    logic [2:0] state;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [2:0] row;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic       btn;
        logic       tick;
        logic       wr;
        logic [2:0] row;
        logic [7:0] data;
        logic [2:0] st;
        logic [6:0] score;
        logic [2:0] lvl;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_exp;
    vec_t vecs[$];

    stacker_engine #(.COLS(8), .ROWS(8), .INIT_LEN(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .step_tick (step_tick),
        .clr_array (clr_array),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .level     (level),
        .score     (score),
        .win       (win),
        .lose      (lose),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic b, input logic t, input logic w, input logic [2:0] r,
                                input logic [7:0] d, input logic [2:0] s, input logic [6:0] sc,
                                input logic [2:0] l);
        vec_t v;
        v.btn = b; v.tick = t; v.wr = w; v.row = r; v.data = d; v.st = s; v.score = sc; v.lvl = l;
        return v;
    endfunction

    task automatic expect_write(input logic [2:0] r, input logic [7:0] d);
        wr_t e;
        e.row = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic b, input logic t);
        btn = b;
        step_tick = t;
        @(posedge clk);
        #1;
        btn = 1'b0;
        step_tick = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [2:0] st, input logic [6:0] sc,
                                input logic [2:0] lvl);
        check({tag, " state"}, state, st);
        check({tag, " score"}, score, sc);
        check({tag, " level"}, level, lvl);
        check({tag, " clr_array"}, clr_array, st == S_INIT);
        check({tag, " win"}, win, st == S_WIN);
        check({tag, " lose"}, lose, st == S_LOSE);
    endtask

    // Every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected write: row %0d data 0x%0h, none expected", wr_row, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write row", wr_row, mon_exp.row);
                check("write data", wr_data, mon_exp.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // btn tick | write row data | state after, score, level
        vecs.push_back(mk(0, 0, 1, 0, 8'hE0, S_MOVE,  0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h70, S_MOVE,  0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, S_PLACE, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h70, S_ALIGN, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, S_ALIGN, 3, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'hE0, S_MOVE,  3, 1));
        vecs.push_back(mk(0, 1, 1, 1, 8'h70, S_MOVE,  3, 1));
        vecs.push_back(mk(0, 1, 1, 1, 8'h38, S_MOVE,  3, 1));
        vecs.push_back(mk(1, 1, 0, 0, 8'h00, S_PLACE, 3, 1));
        vecs.push_back(mk(0, 0, 1, 1, 8'h30, S_ALIGN, 5, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, S_ALIGN, 5, 1));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, S_ALIGN, 5, 1));
        vecs.push_back(mk(0, 0, 1, 2, 8'hC0, S_MOVE,  5, 2));
        vecs.push_back(mk(0, 1, 1, 2, 8'h60, S_MOVE,  5, 2));
        vecs.push_back(mk(0, 1, 1, 2, 8'h30, S_MOVE,  5, 2));
        vecs.push_back(mk(0, 1, 1, 2, 8'h18, S_MOVE,  5, 2));
        vecs.push_back(mk(0, 1, 1, 2, 8'h0C, S_MOVE,  5, 2));
        vecs.push_back(mk(0, 1, 1, 2, 8'h06, S_MOVE,  5, 2));
        vecs.push_back(mk(0, 1, 1, 2, 8'h03, S_MOVE,  5, 2));
        vecs.push_back(mk(0, 1, 1, 2, 8'h06, S_MOVE,  5, 2));
        vecs.push_back(mk(0, 1, 1, 2, 8'h0C, S_MOVE,  5, 2));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, S_PLACE, 5, 2));
        vecs.push_back(mk(0, 0, 1, 2, 8'h00, S_LOSE,  5, 2));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, S_LOSE,  5, 2));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, S_INIT,  0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'hE0, S_MOVE,  0, 0));

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset wr_en", wr_en, 1'b0);
        check_status("reset", S_INIT, 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].wr) expect_write(vecs[i].row, vecs[i].data);
            cycle(vecs[i].btn, vecs[i].tick);
            check_status($sformatf("vec%0d", i), vecs[i].st, vecs[i].score, vecs[i].lvl);
        end

        // Drop immediately on every row: full-width stack up to the top row.
        for (int l = 0; l < 8; l++) begin
            cycle(1'b1, 1'b0);
            check_status($sformatf("win row%0d drop", l), S_PLACE, 7'(3 * l), 3'(l));
            expect_write(3'(l), 8'hE0);
            cycle(1'b0, 1'b0);
            if (l < 7) begin
                check_status($sformatf("win row%0d place", l), S_ALIGN, 7'(3 * (l + 1)), 3'(l));
                expect_write(3'(l + 1), 8'hE0);
                cycle(1'b0, 1'b0);
                check_status($sformatf("win row%0d align", l), S_MOVE, 7'(3 * (l + 1)), 3'(l + 1));
            end else begin
                check_status("win reached", S_WIN, 24, 7);
            end
        end
        cycle(1'b0, 1'b1);
        check_status("win holds on tick", S_WIN, 24, 7);
        cycle(1'b1, 1'b0);
        check_status("win restart", S_INIT, 0, 0);
        expect_write(3'd0, 8'hE0);
        cycle(1'b0, 1'b0);
        check_status("win restart move", S_MOVE, 0, 0);

        // Reset taken while ALIGN is still shifting.
        expect_write(3'd0, 8'h70);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        expect_write(3'd0, 8'h70);
        cycle(1'b0, 1'b0);
        check_status("pre-reset align", S_ALIGN, 3, 0);
        reset = 1'b1;
        cycle(1'b0, 1'b0);
        check_status("mid-align reset", S_INIT, 0, 0);
        check("mid-align reset wr_en", wr_en, 1'b0);
        check("mid-align reset wr_row", wr_row, 3'd0);
        check("mid-align reset wr_data", wr_data, 8'h00);
        reset = 1'b0;
        expect_write(3'd0, 8'hE0);
        cycle(1'b0, 1'b0);
        check_status("post-reset move", S_MOVE, 0, 0);

        repeat (2) cycle(1'b0, 1'b0);
        check("outstanding writes", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stacker_engine.md
Name: stacker_engine

Overview:
Parametrised stacking-game controller for the LED-matrix datapath. It generalises the fixed 8x8 game to COLS x ROWS with configurable starting block length. It adds score accumulation, level reporting and explicit win/lose flags. It drives the row-memory write port and the array-clear strobe; debounce and tick generation sit upstream.

Parameters:
COLS, 8, matrix columns (row word width), >=2
ROWS, 8, matrix rows (levels to win), >=2
INIT_LEN, 3, starting block length in cells, 1..COLS
RW, $clog2(ROWS), row index width
SW, $clog2(COLS*ROWS+1), score width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
btn  in  1  single-cycle drop/ack pulse, pre-debounced
step_tick  in  1  single-cycle movement tick
clr_array  out  1  combinational, high while state==INIT
wr_en  out  1  registered one-cycle row write strobe
wr_row  out  RW  row being written
wr_data  out  COLS  row contents; bit COLS-1 is leftmost
level  out  RW  current row index
score  out  SW  total cells placed
win  out  1  high in WIN
lose  out  1  high in LOSE
state  out  3  current state code

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: state=INIT; wr_en=0, wr_row=0, wr_data=0, level=0, score=0, win=0, lose=0. Reset at any state, including mid-ALIGN, gives INIT on the next cycle.
- Internal registers: cur (moving block), prev (settled row below, initially all ones), dir (RIGHT = toward bit 0).
- INIT (1 cycle):
  - cur = INIT_LEN ones MSB-aligned; prev = all ones; dir = RIGHT; level = 0; score = 0.
  - Writes row 0 with the initial cur (wr_en next cycle), then goes to MOVE.
- MOVE, btn priority:
  - btn=1 (regardless of step_tick): placed = cur & prev, latched; go to PLACE; no shift.
  - step_tick=1, btn=0: bounce check first. Moving RIGHT with cur[0]=1 flips dir to LEFT and shifts left this tick. Moving LEFT with cur[COLS-1]=1 flips to RIGHT and shifts right.
  - If cur is all ones, it does not move.
  - Shifted value is written to row `level`: wr_en pulses 1 cycle after the tick, wr_data = new cur.
  - No tick: wr_en=0.
- PLACE (1 cycle):
  - Writes placed to row `level` (wr_en next cycle).
  - placed==0 -> LOSE.
  - Otherwise score += popcount(placed). Then level==ROWS-1 -> WIN; else prev = placed, cur = placed, go to ALIGN.
- ALIGN:
  - If cur[COLS-1]=0: shift cur left 1 per cycle.
  - If cur[COLS-1]=1: level += 1; write cur to new level; dir = RIGHT; go to MOVE.
  - Latency 1..COLS cycles. prev keeps the unshifted placed position.
- WIN / LOSE:
  - Hold all registers; win or lose held high.
  - btn -> INIT (next cycle clr_array=1, score cleared).
- btn and step_tick are ignored in INIT, PLACE and ALIGN.
- Score saturates at never-exceeded max COLS*ROWS; no wrap. level never exceeds ROWS-1.
- State codes: INIT=000, MOVE=001, PLACE=010, ALIGN=100, WIN=101, LOSE=111. Illegal code -> INIT.

Decomposition:
- stacker_pkg: state encodings, RIGHT/LEFT dir constants, width helper functions.
- Sub-module stacker_popcount: combinational COLS-bit population count, output $clog2(COLS+1) bits.

Test Plan:
- Start: reset 2 cycles, release -> 1 cycle clr_array=1, then wr_en with wr_row=0, wr_data=8'hE0, state=MOVE.
- Move and bounce: one step_tick -> wr_data=8'h70. From cur=8'h07 moving RIGHT, tick -> wr_data=8'h0E, subsequent ticks move left.
- Place and align: cur=8'h70, prev=8'hFF, btn -> PLACE writes row0=8'h70, score=3; 1 ALIGN shift, then row1=8'hE0, level=1. Two ticks (8'h38), btn -> row1=8'h30, score=5.
- Lose: row1 cur=8'h07 over prev=8'hE0, btn -> row written 8'h00, lose=1, score unchanged. btn -> INIT, score=0.
- Win (ROWS=2): btn immediately on rows 0 and 1 -> win=1, score=6, level=1; step_tick ignored until btn.
- Priority and reset: btn and step_tick in the same cycle -> no shift, PLACE taken. reset asserted during ALIGN -> INIT next cycle, all outputs at reset values.
